// File: rtl/phy_rx_sync_ctrl.sv
// phy_rx_sync_ctrl: byte-level link synchronisation for the PHY receive path.
// Hunts for LOCK_COUNT consecutive COM symbols, then forwards payload bytes
// (COM/IDLE stripped) until UNLOCK_COUNT consecutive empty cycles drop lock.
//
// Handshake: valid qualifies in for exactly the cycle it is high; there is no
// backpressure. valid_out qualifies out for exactly one cycle per forwarded
// byte, one cycle after that byte was sampled; out holds when valid_out=0.
module phy_rx_sync_ctrl #(
  parameter logic [7:0] COM_SYM      = 8'hBC,
  parameter logic [7:0] IDLE_SYM     = 8'h7C,
  parameter int         LOCK_COUNT   = 4,
  parameter int         UNLOCK_COUNT = 3
) (
  input  logic       clk4f,
  input  logic       reset,
  input  logic [7:0] in,
  input  logic       valid,
  output logic [7:0] out,
  output logic       valid_out,
  output logic       active,
  output logic [1:0] state,
  output logic [3:0] com_cnt,
  output logic [3:0] err_cnt,
  output logic [7:0] lock_loss_cnt
);

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_SEARCH = 2'd1,
    ST_ALIGN  = 2'd2,
    ST_ACTIVE = 2'd3
  } state_t;

  localparam logic [3:0] LOCK_CNT4   = 4'(LOCK_COUNT);
  localparam logic [3:0] UNLOCK_CNT4 = 4'(UNLOCK_COUNT);

  state_t     r_state;
  logic [7:0] r_out;
  logic       r_valid_out;
  logic       r_active;
  logic [3:0] r_com_cnt;
  logic [3:0] r_err_cnt;
  logic [7:0] r_lock_loss_cnt;

  logic       w_is_com;
  logic       w_is_idle;
  logic [3:0] w_com_inc;
  logic [3:0] w_err_inc;

  // Symbol decode and next counter values shared by the FSM.
  always_comb begin
    w_is_com  = valid && (in == COM_SYM);
    w_is_idle = valid && (in == IDLE_SYM);
    w_com_inc = r_com_cnt + 4'd1;
    w_err_inc = r_err_cnt + 4'd1;
  end

  // Sync FSM with all outputs registered; active mirrors entry/exit of ACTIVE.
  always_ff @(posedge clk4f) begin
    if (reset) begin
      r_state         <= ST_RESET;
      r_out           <= 8'h00;
      r_valid_out     <= 1'b0;
      r_active        <= 1'b0;
      r_com_cnt       <= 4'd0;
      r_err_cnt       <= 4'd0;
      r_lock_loss_cnt <= 8'h00;
    end else begin
      case (r_state)
        ST_RESET: begin
          r_state     <= ST_SEARCH;
          r_valid_out <= 1'b0;
          r_active    <= 1'b0;
          r_com_cnt   <= 4'd0;
          r_err_cnt   <= 4'd0;
        end

        ST_SEARCH: begin
          r_valid_out <= 1'b0;
          if (w_is_com) begin
            if (LOCK_CNT4 == 4'd1) begin
              r_state   <= ST_ACTIVE;
              r_active  <= 1'b1;
              r_com_cnt <= 4'd0;
              r_err_cnt <= 4'd0;
            end else begin
              r_state   <= ST_ALIGN;
              r_com_cnt <= 4'd1;
            end
          end else begin
            r_com_cnt <= 4'd0;
          end
        end

        ST_ALIGN: begin
          r_valid_out <= 1'b0;
          if (w_is_com) begin
            if (w_com_inc == LOCK_CNT4) begin
              r_state   <= ST_ACTIVE;
              r_active  <= 1'b1;
              r_com_cnt <= 4'd0;
              r_err_cnt <= 4'd0;
            end else begin
              r_com_cnt <= w_com_inc;
            end
          end else begin
            r_state   <= ST_SEARCH;
            r_com_cnt <= 4'd0;
          end
        end

        ST_ACTIVE: begin
          if (valid) begin
            r_err_cnt <= 4'd0;
            if (w_is_com || w_is_idle) begin
              r_valid_out <= 1'b0;
            end else begin
              r_out       <= in;
              r_valid_out <= 1'b1;
            end
          end else begin
            r_valid_out <= 1'b0;
            if (w_err_inc == UNLOCK_CNT4) begin
              r_state   <= ST_SEARCH;
              r_active  <= 1'b0;
              r_err_cnt <= 4'd0;
              if (r_lock_loss_cnt != 8'hFF) begin
                r_lock_loss_cnt <= r_lock_loss_cnt + 8'd1;
              end
            end else begin
              r_err_cnt <= w_err_inc;
            end
          end
        end

        default: begin
          r_state <= ST_RESET;
        end
      endcase
    end
  end

  assign out           = r_out;
  assign valid_out     = r_valid_out;
  assign active        = r_active;
  assign state         = r_state;
  assign com_cnt       = r_com_cnt;
  assign err_cnt       = r_err_cnt;
  assign lock_loss_cnt = r_lock_loss_cnt;

endmodule
